// File: rtl/calc_port_scheduler_pkg.sv
// rtl/calc_port_scheduler_pkg.sv - shared types for the four-port calculator front end
package calc_pkg;

  localparam int CALC_PORTS  = 4;
  localparam int CALC_DATA_W = 32;
  localparam int CALC_TAG_W  = $clog2(CALC_PORTS);

  typedef enum logic [3:0] {
    NOP = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    SHL = 4'd5,
    SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    OK      = 2'b01,
    OVFL    = 2'b10,
    INVALID = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    IDLE,
    GET_OP2,
    PENDING,
    INFLIGHT
  } port_state_e;

  typedef struct packed {
    logic                   valid;
    logic [CALC_TAG_W-1:0]  tag;
    logic [3:0]             cmd;
    logic [CALC_DATA_W-1:0] op1;
    logic [CALC_DATA_W-1:0] op2;
  } dispatch_t;

  typedef struct packed {
    logic                   valid;
    logic [CALC_TAG_W-1:0]  tag;
    resp_e                  resp;
    logic [CALC_DATA_W-1:0] data;
  } result_t;

  function automatic logic is_valid_cmd(input logic [3:0] c);
    return (c == ADD) || (c == SUB) || (c == SHL) || (c == SHR);
  endfunction

endpackage

// File: rtl/calc_port_scheduler_if.sv
// rtl/calc_port_scheduler_if.sv - per-port request/response bundle of the calculator
interface calc_port_scheduler_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32
);

  logic [NUM_PORTS-1:0][3:0]        req_cmd_in;
  logic [NUM_PORTS-1:0][DATA_W-1:0] req_data_in;
  logic [NUM_PORTS-1:0][1:0]        out_resp;
  logic [NUM_PORTS-1:0][DATA_W-1:0] out_data;
  logic [NUM_PORTS-1:0]             busy;
  logic [NUM_PORTS-1:0]             drop_err;

  modport master (
    output req_cmd_in, req_data_in,
    input  out_resp, out_data, busy, drop_err
  );

  modport slave (
    input  req_cmd_in, req_data_in,
    output out_resp, out_data, busy, drop_err
  );

endinterface

// File: rtl/calc_port_scheduler_alu_pipe.sv
// rtl/calc_port_scheduler_alu_pipe.sv - shared arithmetic pipeline fed by the dispatch register
// The dispatch register upstream is the first stage, so LATENCY-1 stages live here.
module calc_alu_pipe
  import calc_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  dispatch_t disp_i,
  output result_t   res_o
);

  result_t res_c;

  always_comb begin
    logic [CALC_DATA_W:0] sum;
    sum        = {1'b0, disp_i.op1} + {1'b0, disp_i.op2};
    res_c.valid = disp_i.valid;
    res_c.tag   = disp_i.tag;
    res_c.resp  = OK;
    res_c.data  = '0;
    case (disp_i.cmd)
      ADD: if (sum[CALC_DATA_W]) res_c.resp = OVFL;
           else res_c.data = sum[CALC_DATA_W-1:0];
      SUB: if (disp_i.op2 > disp_i.op1) res_c.resp = OVFL;
           else res_c.data = disp_i.op1 - disp_i.op2;
      SHL: res_c.data = disp_i.op1 << disp_i.op2[4:0];
      SHR: res_c.data = disp_i.op1 >> disp_i.op2[4:0];
      default: res_c.resp = INVALID;
    endcase
  end

  if (LATENCY <= 1) begin : g_comb
    assign res_o = res_c;
  end else begin : g_reg
    result_t stage_q [LATENCY-1];

    always_ff @(posedge clk_i) begin
      stage_q[0] <= res_c;
      for (int i = 1; i < LATENCY - 1; i++) stage_q[i] <= stage_q[i-1];
      if (rst_i) begin
        for (int i = 0; i < LATENCY - 1; i++) stage_q[i].valid <= 1'b0;
      end
    end

    assign res_o = stage_q[LATENCY-2];
  end

endmodule

// File: rtl/calc_port_scheduler.sv
// rtl/calc_port_scheduler.sv - per-port request capture, round-robin dispatch and response routing
module calc_port_scheduler
  import calc_pkg::*;
#(
  parameter int NUM_PORTS = CALC_PORTS,
  parameter int DATA_W    = CALC_DATA_W,
  parameter int LATENCY   = 2
) (
  input  logic                   c_clk,
  input  logic                   reset,
  calc_port_scheduler_if.slave   bus
);

  localparam int TAG_W = CALC_TAG_W;

  port_state_e                      state_q [NUM_PORTS];
  port_state_e                      state_d [NUM_PORTS];
  logic [3:0]                       cmd_q [NUM_PORTS], cmd_d [NUM_PORTS];
  logic [DATA_W-1:0]                op1_q [NUM_PORTS], op1_d [NUM_PORTS];
  logic [DATA_W-1:0]                op2_q [NUM_PORTS], op2_d [NUM_PORTS];
  logic [NUM_PORTS-1:0][1:0]        resp_q, resp_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] data_q, data_d;
  logic [NUM_PORTS-1:0]             busy_w, drop_w;
  logic [TAG_W-1:0]                 ptr_q, ptr_d, gnt_idx;
  logic                             gnt_valid;
  dispatch_t                        disp_q, disp_d;
  result_t                          res;

  always_comb begin : arb
    int idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (int'(ptr_q) + k) % NUM_PORTS;
      if (!gnt_valid && state_q[idx] == PENDING) begin
        gnt_valid = 1'b1;
        gnt_idx   = TAG_W'(idx);
      end
    end
    ptr_d = ptr_q;
    if (gnt_valid) ptr_d = (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
    disp_d.valid = gnt_valid;
    disp_d.tag   = gnt_idx;
    disp_d.cmd   = cmd_q[gnt_idx];
    disp_d.op1   = op1_q[gnt_idx];
    disp_d.op2   = op2_q[gnt_idx];
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    resp_d  = '0;
    data_d  = '0;
    busy_w  = '0;
    drop_w  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      busy_w[p] = state_q[p] != IDLE;
      case (state_q[p])
        IDLE: if (bus.req_cmd_in[p] != 4'd0) begin
          state_d[p] = GET_OP2;
          cmd_d[p]   = bus.req_cmd_in[p];
          op1_d[p]   = bus.req_data_in[p];
        end
        GET_OP2: begin
          op2_d[p] = bus.req_data_in[p];
          if (is_valid_cmd(cmd_q[p])) begin
            state_d[p] = PENDING;
          end else begin
            state_d[p] = IDLE;
            resp_d[p]  = INVALID;
          end
        end
        PENDING: begin
          drop_w[p] = bus.req_cmd_in[p] != 4'd0;
          if (gnt_valid && int'(gnt_idx) == p) state_d[p] = INFLIGHT;
        end
        INFLIGHT: begin
          drop_w[p] = bus.req_cmd_in[p] != 4'd0;
          // Tags are unique among in-flight ops, so at most one port matches.
          if (res.valid && int'(res.tag) == p) begin
            state_d[p] = IDLE;
            resp_d[p]  = res.resp;
            data_d[p]  = res.data;
          end
        end
        default: state_d[p] = IDLE;
      endcase
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) state_q[p] <= IDLE;
      resp_q       <= '0;
      data_q       <= '0;
      ptr_q        <= '0;
      disp_q       <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      disp_q  <= disp_d;
    end
  end

  always_ff @(posedge c_clk) begin
    cmd_q <= cmd_d;
    op1_q <= op1_d;
    op2_q <= op2_d;
  end

  calc_alu_pipe #(.LATENCY(LATENCY)) u_alu (
    .clk_i  (c_clk),
    .rst_i  (reset),
    .disp_i (disp_q),
    .res_o  (res)
  );

  assign bus.out_resp = resp_q;
  assign bus.out_data = data_q;
  assign bus.busy     = busy_w;
  assign bus.drop_err = drop_w;

endmodule

// File: tb/tb_calc_port_scheduler.sv
// tb/tb_calc_port_scheduler.sv - directed and randomized check of calc_port_scheduler against a transaction model
module tb_calc_port_scheduler;
  import calc_pkg::*;

  localparam int NP  = 4;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic c_clk = 1'b0;
  logic reset = 1'b1;

  calc_port_scheduler_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus ();

  calc_port_scheduler #(.NUM_PORTS(NP), .DATA_W(DW), .LATENCY(LAT)) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 c_clk = ~c_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction model: phase 0 free, 1 awaiting op2, 2 waiting for grant, 3 executing.
  int          ph [NP];
  logic [3:0]  mcmd [NP];
  logic [31:0] mop1 [NP], mop2 [NP];
  int          due [NP];
  int          ptr;
  logic [1:0]  exp_resp [NP];
  logic [31:0] exp_data [NP];
  int          cyc;
  bit          chk_en;

  logic [3:0]  cmd_v [NP];
  logic [31:0] data_v [NP];
  int          seen_cyc [NP], resp_cnt [NP], drop_cnt [NP];
  logic [1:0]  seen_resp [NP];
  logic [31:0] seen_data [NP];
  bit          op2_next [NP];

  function automatic void ref_calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                   output logic [1:0] r, output logic [31:0] d);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    r = 2'b01;
    d = 32'd0;
    case (c)
      4'd1: if (s[32]) r = 2'b10; else d = s[31:0];
      4'd2: if (b > a) r = 2'b10; else d = a - b;
      4'd5: d = a << b[4:0];
      4'd6: d = a >> b[4:0];
      default: r = 2'b11;
    endcase
  endfunction

  task automatic model_update();
    int          cur [NP];
    logic [1:0]  nr [NP];
    logic [31:0] nd [NP];
    int          q;
    for (int p = 0; p < NP; p++) begin
      cur[p] = ph[p];
      nr[p]  = 2'b00;
      nd[p]  = 32'd0;
    end
    if (reset) begin
      for (int p = 0; p < NP; p++) ph[p] = 0;
      ptr = 0;
    end else begin
      for (int p = 0; p < NP; p++)
        if (cur[p] == 3 && due[p] == cyc + 1) begin
          ref_calc(mcmd[p], mop1[p], mop2[p], nr[p], nd[p]);
          ph[p] = 0;
        end
      for (int k = 0; k < NP; k++) begin
        q = (ptr + k) % NP;
        if (cur[q] == 2) begin
          ph[q]  = 3;
          due[q] = cyc + 1 + LAT;
          ptr    = (q + 1) % NP;
          break;
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (cur[p] == 1) begin
          mop2[p] = data_v[p];
          if (mcmd[p] inside {4'd1, 4'd2, 4'd5, 4'd6}) ph[p] = 2;
          else begin
            ph[p] = 0;
            nr[p] = 2'b11;
          end
        end else if (cur[p] == 0 && cmd_v[p] != 4'd0) begin
          ph[p]   = 1;
          mcmd[p] = cmd_v[p];
          mop1[p] = data_v[p];
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      exp_resp[p] = nr[p];
      exp_data[p] = nd[p];
    end
  endtask

  task automatic cycle();
    for (int p = 0; p < NP; p++) begin
      bus.req_cmd_in[p]  = cmd_v[p];
      bus.req_data_in[p] = data_v[p];
    end
    @(negedge c_clk);
    if (chk_en) begin
      for (int p = 0; p < NP; p++) begin
        check($sformatf("resp[%0d]@%0d", p, cyc), bus.out_resp[p], exp_resp[p]);
        check($sformatf("data[%0d]@%0d", p, cyc), bus.out_data[p], exp_data[p]);
        check($sformatf("busy[%0d]@%0d", p, cyc), bus.busy[p], ph[p] != 0);
        check($sformatf("drop[%0d]@%0d", p, cyc), bus.drop_err[p], cmd_v[p] != 4'd0 && ph[p] >= 2);
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (bus.out_resp[p] != 2'b00) begin
        seen_cyc[p]  = cyc;
        seen_resp[p] = bus.out_resp[p];
        seen_data[p] = bus.out_data[p];
        resp_cnt[p]++;
      end
      if (bus.drop_err[p]) drop_cnt[p]++;
    end
    model_update();
    @(posedge c_clk);
    #1;
    cyc++;
    for (int p = 0; p < NP; p++) begin
      cmd_v[p]  = 4'd0;
      data_v[p] = $urandom;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clr_seen();
    for (int p = 0; p < NP; p++) begin
      seen_cyc[p] = -1;
      resp_cnt[p] = 0;
      drop_cnt[p] = 0;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    idle(n);
    reset = 1'b0;
  endtask

  logic [1:0]  t_port [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
  logic [3:0]  t_cmd  [5] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd2};
  logic [31:0] t_a    [5] = '{32'hFFFF_FFFF, 32'h22, 32'h3, 32'hC, 32'h23};
  logic [31:0] t_b    [5] = '{32'h1, 32'h23, 32'h2, 32'h2, 32'h23};
  logic [1:0]  t_resp [5] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b01};
  logic [31:0] t_data [5] = '{32'h0, 32'h0, 32'hC, 32'h3, 32'h0};

  initial begin
    int t0;
    int p;
    cyc = 0;
    ptr = 0;
    chk_en = 1'b0;
    for (int i = 0; i < NP; i++) begin
      ph[i] = 0; due[i] = 0; exp_resp[i] = 2'b00; exp_data[i] = 32'd0;
      cmd_v[i] = 4'd0; data_v[i] = 32'd0; op2_next[i] = 1'b0;
    end
    clr_seen();
    do_reset(2);
    chk_en = 1'b1;

    check("rst_resp", bus.out_resp, '0);
    check("rst_busy", bus.busy, '0);

    t0 = cyc;
    cmd_v[0] = 4'd1; data_v[0] = 32'h5; cycle();
    data_v[0] = 32'h1; cycle();
    idle(6);
    check("p0_add_lat", seen_cyc[0] - t0, 5);
    check("p0_add_data", seen_data[0], 32'h6);
    check("others_silent", resp_cnt[1] + resp_cnt[2] + resp_cnt[3], 0);

    for (int i = 0; i < 5; i++) begin
      clr_seen();
      p = int'(t_port[i]);
      t0 = cyc;
      cmd_v[p] = t_cmd[i]; data_v[p] = t_a[i]; cycle();
      data_v[p] = t_b[i]; cycle();
      idle(6);
      check($sformatf("tbl%0d_lat", i), seen_cyc[p] - t0, 5);
      check($sformatf("tbl%0d_resp", i), seen_resp[p], t_resp[i]);
      check($sformatf("tbl%0d_data", i), seen_data[p], t_data[i]);
    end

    do_reset(1);
    clr_seen();
    t0 = cyc;
    for (int i = 0; i < NP; i++) begin cmd_v[i] = 4'd1; data_v[i] = 32'(i); end
    cycle();
    for (int i = 0; i < NP; i++) data_v[i] = 32'h10;
    cycle();
    idle(9);
    for (int i = 0; i < NP; i++) begin
      check($sformatf("all4_lat%0d", i), seen_cyc[i] - t0, 5 + i);
      check($sformatf("all4_data%0d", i), seen_data[i], 32'h10 + 32'(i));
    end

    cmd_v[0] = 4'd1; cycle(); idle(7);
    clr_seen();
    t0 = cyc;
    cmd_v[1] = 4'd1; cmd_v[3] = 4'd1; cycle();
    idle(8);
    check("rr_p1_first", seen_cyc[1] - t0, 5);
    check("rr_p3_second", seen_cyc[3] - t0, 6);

    clr_seen();
    t0 = cyc;
    cmd_v[2] = 4'h9; cycle();
    idle(12);
    check("inv_lat", seen_cyc[2] - t0, 2);
    check("inv_resp", seen_resp[2], 2'b11);
    check("nop_silent", resp_cnt[0], 0);

    clr_seen();
    t0 = cyc;
    cmd_v[1] = 4'd1; data_v[1] = 32'h7; cycle();
    data_v[1] = 32'h8; cycle();
    cycle();
    cmd_v[1] = 4'd2; cycle();
    cycle();
    cmd_v[1] = 4'd1; data_v[1] = 32'h100; cycle();
    data_v[1] = 32'h1; cycle();
    idle(6);
    check("drop_cnt", drop_cnt[1], 1);
    check("resp_cnt", resp_cnt[1], 2);
    check("back2back_lat", seen_cyc[1] - t0, 10);
    check("back2back_data", seen_data[1], 32'h101);

    clr_seen();
    cmd_v[0] = 4'd1; cycle(); idle(2);
    do_reset(1);
    idle(8);
    check("rst_no_resp", resp_cnt[0], 0);
    t0 = cyc;
    cmd_v[0] = 4'd1; cmd_v[3] = 4'd1; cycle();
    idle(8);
    check("post_rst_p0", seen_cyc[0] - t0, 5);
    check("post_rst_p3", seen_cyc[3] - t0, 6);

    for (int n = 0; n < 600; n++) begin
      logic [3:0] pick [7] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd9, 4'd3, 4'd15};
      reset = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < NP; i++) begin
        data_v[i] = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        if (op2_next[i]) op2_next[i] = 1'b0;
        else if ($urandom_range(0, 2) == 0) begin
          cmd_v[i] = pick[$urandom_range(0, 6)];
          op2_next[i] = 1'b1;
        end
      end
      cycle();
    end
    reset = 1'b0;
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
